mmio_tx_fifo: RTL and testbench

MMIO_TX_FIFO -- requirements
Module: mmio_tx_fifo

---
 rtl/mmio_tx_fifo.sv | 130 +++++++++++++
 tb/tb_mmio_tx_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_tx_fifo.sv
// Memory-mapped transmit FIFO: CPU stores into TXDATA, entries drain on a valid/ready stream.
// Register reads are combinational; out_valid holds until out_ready, full pushes are dropped with sticky ovf.
module mmio_tx_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0000,
  parameter int unsigned DEPTH     = 8
) (
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        irq
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          drain_en_q, drain_en_d;
  logic          irq_en_q, irq_en_d;
  logic          irq_q, irq_d;
  logic [15:0]   thresh_q, thresh_d;

  logic [3:0] offset;
  logic       empty, full;
  logic       push_req, push, pop, flush, ovf_clr, ctrl_wr, thresh_wr;

  assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
  assign offset    = addr[3:0];
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign out_valid = drain_en_q & ~empty;
  assign out_data  = mem[rd_ptr_q];
  assign irq       = irq_q;

  assign pop       = out_valid & out_ready & clk_en;
  assign push_req  = wr_en & sel & (offset == 4'h0) & clk_en;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push      = push_req & (~full | pop);
  assign ctrl_wr   = wr_en & sel & (offset == 4'h8) & clk_en;
  assign thresh_wr = wr_en & sel & (offset == 4'hC) & clk_en;
  assign flush     = ctrl_wr & w_data[31];
  assign ovf_clr   = rd_en & sel & (offset == 4'h4) & clk_en;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    drain_en_d = drain_en_q;
    irq_en_d   = irq_en_q;
    thresh_d   = thresh_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // Set beats clear when both land on one edge.
      if (push_req && !push) ovf_d = 1'b1;
      else if (ovf_clr)      ovf_d = 1'b0;
    end

    if (ctrl_wr) begin
      drain_en_d = w_data[0];
      irq_en_d   = w_data[1];
    end
    if (thresh_wr) thresh_d = w_data[15:0];

    irq_d = irq_en_d & (16'(count_d) <= thresh_d);
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      drain_en_q <= 1'b0;
      irq_en_q   <= 1'b0;
      thresh_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      drain_en_q <= drain_en_d;
      irq_en_q   <= irq_en_d;
      thresh_q   <= thresh_d;
      irq_q      <= irq_d;
    end
  end

  // Storage is left unreset; the pointers alone define what is valid.
  always_ff @(posedge clk_100M) begin
    if (push) mem[wr_ptr_q] <= w_data;
  end

  always_comb begin
    r_data = '0;
    if (sel && offset[1:0] == 2'b00) begin
      case (offset[3:2])
        2'd1:    r_data = {13'b0, ovf_q, full, empty, 16'(count_q)};
        2'd2:    r_data = {30'b0, irq_en_q, drain_en_q};
        2'd3:    r_data = {16'b0, thresh_q};
        default: r_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_tx_fifo.sv
// Bench for mmio_tx_fifo: directed scenarios plus randomized traffic against a queue-based model.
module tb_mmio_tx_fifo;
  localparam logic [31:0] BASE  = 32'hFFFF0000;
  localparam int          DEPTH = 8;

  logic        clk_100M = 1'b0;
  logic        rst_n    = 1'b0;
  logic        clk_en   = 1'b0;
  logic [31:0] addr     = '0;
  logic        wr_en    = 1'b0;
  logic        rd_en    = 1'b0;
  logic [31:0] w_data   = '0;
  logic        out_ready = 1'b0;
  logic [31:0] r_data, out_data;
  logic        sel, out_valid, irq;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic [31:0] exp_pop[$];
  logic [31:0] got_pop[$];
  bit          m_ovf, m_drain, m_irqen, m_irq;
  logic [15:0] m_thresh;

  mmio_tx_fifo #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk_100M (clk_100M), .rst_n (rst_n), .clk_en (clk_en),
    .addr (addr), .wr_en (wr_en), .rd_en (rd_en), .w_data (w_data),
    .r_data (r_data), .sel (sel),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
    .irq (irq)
  );

  always #5 clk_100M = ~clk_100M;

  function automatic logic [31:0] m_status();
    return {13'b0, m_ovf, (mq.size() == DEPTH), (mq.size() == 0), 16'(mq.size())};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_drain = 0; m_irqen = 0; m_irq = 0; m_thresh = '0;
  endtask

  task automatic model_step(input logic [31:0] a, input logic we, input logic re,
                            input logic [31:0] wd, input logic ordy, input logic cen);
    bit hit, pop, push, flush;
    int cnt;
    if (!cen) return;
    hit   = (a[31:4] == BASE[31:4]);
    cnt   = mq.size();
    pop   = ordy && m_drain && cnt > 0;
    push  = we && hit && a[3:0] == 4'h0;
    flush = we && hit && a[3:0] == 4'h8 && wd[31];
    if (pop) exp_pop.push_back(mq[0]);
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (cnt < DEPTH || pop) mq.push_back(wd);
        else m_ovf = 1;
      end else if (re && hit && a[3:0] == 4'h4) m_ovf = 0;
    end
    if (we && hit && a[3:0] == 4'h8) begin m_drain = wd[0]; m_irqen = wd[1]; end
    if (we && hit && a[3:0] == 4'hC) m_thresh = wd[15:0];
    m_irq = m_irqen && (mq.size() <= int'(m_thresh));
  endtask

  // Drives one clock edge worth of inputs, logs stream handshakes, advances the model.
  task automatic cycle(input logic [31:0] a, input logic we, input logic re,
                       input logic [31:0] wd, input logic ordy, input logic cen);
    addr = a; wr_en = we; rd_en = re; w_data = wd; out_ready = ordy; clk_en = cen;
    #1;
    if (out_valid && out_ready && clk_en) got_pop.push_back(out_data);
    @(posedge clk_100M);
    model_step(a, we, re, wd, ordy, cen);
    #1;
    wr_en = 0; rd_en = 0; out_ready = 0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 0;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b expected 0", out_valid); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq got %b expected 0", irq); end
    #7 rst_n = 1;
    @(posedge clk_100M); #1;
    addr = BASE + 4; #1;
    n_cmp++; if (r_data !== 32'h00010000) begin n_bad++; $display("FAIL rst_status got %h expected 00010000", r_data); end
    n_cmp++; if (sel !== 1'b1) begin n_bad++; $display("FAIL rst_sel got %b expected 1", sel); end
    n_cmp++; if (out_valid !== 1'b0 || irq !== 1'b0) begin n_bad++; $display("FAIL rst_outputs got v=%b irq=%b expected 0/0", out_valid, irq); end
  endtask

  task automatic test_overflow();
    for (int v = 1; v <= 9; v++) cycle(BASE, 1, 0, 32'(v), 0, 1);
    addr = BASE + 4; #1;
    n_cmp++; if (r_data !== 32'h00060008) begin n_bad++; $display("FAIL ovf_status got %h expected 00060008", r_data); end
    cycle(BASE + 4, 0, 1, 0, 0, 1);
    addr = BASE + 4; #1;
    n_cmp++; if (r_data !== 32'h00020008) begin n_bad++; $display("FAIL ovf_clear got %h expected 00020008", r_data); end
  endtask

  task automatic test_full_pushpop();
    logic [31:0] exp_seq[9];
    for (int i = 0; i < 8; i++) exp_seq[i] = 32'(i + 1);
    exp_seq[8] = 32'hA;
    cycle(BASE + 8, 1, 0, 32'h1, 0, 1);
    got_pop.delete(); exp_pop.delete();
    cycle(BASE, 1, 0, 32'hA, 1, 1);
    addr = BASE + 4; #1;
    n_cmp++; if (r_data !== 32'h00020008) begin n_bad++; $display("FAIL full_pushpop_status got %h expected 00020008", r_data); end
    repeat (12) cycle(BASE + 12, 0, 0, 0, 1, 1);
    n_cmp++; if (got_pop.size() != 9) begin n_bad++; $display("FAIL full_pushpop_len got %0d expected 9", got_pop.size()); end
    for (int i = 0; i < 9 && i < got_pop.size(); i++) begin
      n_cmp++; if (got_pop[i] !== exp_seq[i]) begin n_bad++; $display("FAIL full_pushpop_data[%0d] got %h expected %h", i, got_pop[i], exp_seq[i]); end
    end
    addr = BASE + 4; #1;
    n_cmp++; if (r_data !== 32'h00010000) begin n_bad++; $display("FAIL full_pushpop_empty got %h expected 00010000", r_data); end
    cycle(BASE + 8, 1, 0, 32'h0, 0, 1);
  endtask

  task automatic test_irq();
    int first_cnt = -1;
    for (int v = 0; v < 5; v++) cycle(BASE, 1, 0, 32'h10 + 32'(v), 0, 1);
    cycle(BASE + 12, 1, 0, 32'h2, 0, 1);
    cycle(BASE + 8, 1, 0, 32'h3, 0, 1);
    #1;
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_above_thresh got %b expected 0", irq); end
    for (int i = 0; i < 8; i++) begin
      cycle(BASE + 12, 0, 0, 0, 1, 1);
      addr = BASE + 4; #1;
      n_cmp++; if (irq !== m_irq) begin n_bad++; $display("FAIL irq_level[%0d] got %b expected %b", i, irq, m_irq); end
      if (irq === 1'b1 && first_cnt < 0) first_cnt = int'(r_data[15:0]);
    end
    n_cmp++; if (first_cnt != 2) begin n_bad++; $display("FAIL irq_rise_count got %0d expected 2", first_cnt); end
    cycle(BASE + 8, 1, 0, 32'h0, 0, 1);
    #1;
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_disable got %b expected 0", irq); end
  endtask

  task automatic test_flush();
    for (int v = 0; v < 4; v++) cycle(BASE, 1, 0, 32'h20 + 32'(v), 0, 1);
    cycle(BASE + 8, 1, 0, 32'h1, 0, 1);
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_pre_valid got %b expected 1", out_valid); end
    cycle(BASE + 8, 1, 0, 32'h80000001, 1, 1);
    addr = BASE + 4; #1;
    n_cmp++; if (r_data !== 32'h00010000) begin n_bad++; $display("FAIL flush_status got %h expected 00010000", r_data); end
    addr = BASE + 8; #1;
    n_cmp++; if (r_data !== 32'h00000001) begin n_bad++; $display("FAIL flush_ctrl got %h expected 00000001", r_data); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %b expected 0", out_valid); end
    cycle(BASE + 8, 1, 0, 32'h0, 0, 1);
  endtask

  task automatic test_decode_and_async_reset();
    addr = BASE + 16; #1;
    n_cmp++; if (sel !== 1'b0 || r_data !== 32'h0) begin n_bad++; $display("FAIL miss_decode got sel=%b r=%h expected 0/0", sel, r_data); end
    addr = BASE + 6; #1;
    n_cmp++; if (sel !== 1'b1 || r_data !== 32'h0) begin n_bad++; $display("FAIL unaligned_read got sel=%b r=%h expected 1/0", sel, r_data); end
    cycle(BASE + 4, 1, 0, 32'hFFFFFFFF, 0, 1);
    cycle(BASE + 2, 1, 0, 32'hFFFFFFFF, 0, 1);
    cycle(BASE + 16, 1, 0, 32'h5, 0, 1);
    cycle(BASE, 1, 0, 32'h5, 0, 0);
    addr = BASE + 4; #1;
    n_cmp++; if (r_data !== 32'h00010000) begin n_bad++; $display("FAIL no_side_effect_status got %h expected 00010000", r_data); end
    for (int v = 0; v < 3; v++) cycle(BASE, 1, 0, 32'h30 + 32'(v), 0, 1);
    cycle(BASE + 8, 1, 0, 32'h1, 0, 1);
    addr = BASE + 4; #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_drain_valid got %b expected 1", out_valid); end
    rst_n = 0; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL async_reset_valid got %b expected 0", out_valid); end
    n_cmp++; if (r_data !== 32'h00010000) begin n_bad++; $display("FAIL async_reset_status got %h expected 00010000", r_data); end
    #3 rst_n = 1;
    model_reset();
    @(posedge clk_100M); #1;
    addr = BASE + 8; #1;
    n_cmp++; if (r_data !== 32'h0) begin n_bad++; $display("FAIL post_reset_ctrl got %h expected 0", r_data); end
  endtask

  task automatic test_random();
    got_pop.delete(); exp_pop.delete();
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, wd;
      logic we, re, ordy, cen;
      int kind;
      kind = $urandom_range(0, 9);
      a = BASE; we = 0; re = 0; wd = $urandom;
      case (kind)
        0, 1, 2, 3: we = 1;
        4: begin a = BASE + 4; re = 1; end
        5: begin a = BASE + 8; we = 1; wd = {($urandom_range(0, 9) == 0), 29'($urandom), 2'($urandom)}; end
        6: begin a = BASE + 12; we = 1; wd = ($urandom & 32'hFFFF0000) | 32'($urandom_range(0, 9)); end
        7: begin a = BASE + 16 + 32'($urandom_range(0, 3) * 4); we = 1; end
        8: begin a = BASE + 32'($urandom_range(1, 3)); we = 1; end
        default: a = BASE + 12;
      endcase
      ordy = ($urandom_range(0, 3) != 0);
      cen  = ($urandom_range(0, 7) != 0);
      cycle(a, we, re, wd, ordy, cen);
      addr = BASE + 4; #1;
      n_cmp++; if (r_data !== m_status()) begin n_bad++; $display("FAIL rand_status[%0d] got %h expected %h", i, r_data, m_status()); end
      n_cmp++; if (irq !== m_irq) begin n_bad++; $display("FAIL rand_irq[%0d] got %b expected %b", i, irq, m_irq); end
      n_cmp++; if (out_valid !== (m_drain && mq.size() > 0)) begin n_bad++; $display("FAIL rand_valid[%0d] got %b expected %b", i, out_valid, (m_drain && mq.size() > 0)); end
    end
    addr = BASE + 12; #1;
    n_cmp++; if (r_data !== {16'b0, m_thresh}) begin n_bad++; $display("FAIL rand_thresh got %h expected %h", r_data, {16'b0, m_thresh}); end
    n_cmp++; if (got_pop.size() != exp_pop.size()) begin n_bad++; $display("FAIL rand_pop_len got %0d expected %0d", got_pop.size(), exp_pop.size()); end
    for (int i = 0; i < got_pop.size() && i < exp_pop.size(); i++) begin
      n_cmp++; if (got_pop[i] !== exp_pop[i]) begin n_bad++; $display("FAIL rand_pop[%0d] got %h expected %h", i, got_pop[i], exp_pop[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_full_pushpop();
    test_irq();
    test_flush();
    test_decode_and_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
